// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage following stage_ex.
// Holds one execute result at a time. Non-memory results pass through in one
// cycle. Loads and stores run a req/ack transaction on the data-memory port.
// Loads are aligned and sign- or zero-extended. Stores get lane-replicated
// write data and byte enables. Illegal or misaligned memory ops fault without
// issuing a request.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in, in_valid, in_ready       execute result and its handshake
//   dmem_req/we/addr/be/wdata    registered data-memory request
//   dmem_ack, dmem_rdata         one-cycle completion pulse and read word
//   out_valid, out_ready         result handshake toward writeback
//   out_pc/rd/rd_valid/data/fault registered writeback result

package rvcpu;
  localparam int Width = 32;
  typedef logic [31:0] pc_t;
  typedef logic [4:0]  reg_t;
  typedef struct packed {
    pc_t         pc;
    reg_t        rd;
    logic        rd_valid;
    logic        is_mem;
    logic [3:0]  op;      // [3] store, [2:0] funct3
    logic [31:0] addr;
    logic [31:0] data;    // store data (rs2) for memory ops
  } stage_ex_t;
endpackage

module stage_mem #(
  parameter int Width = rvcpu::Width
) (
  input  logic             clk,
  input  logic             rst,
  input  rvcpu::stage_ex_t in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [Width-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [Width-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [Width-1:0] dmem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output rvcpu::pc_t       out_pc,
  output rvcpu::reg_t      out_rd,
  output logic             out_rd_valid,
  output logic [Width-1:0] out_data,
  output logic             out_fault
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [2:0]  ld_f3;
  rvcpu::pc_t  pc_q;
  rvcpu::reg_t rd_q;
  logic        rdv_q;

  // Decode of the incoming op
  logic [2:0]  f3;
  logic        st, legal, misal, fault, accept;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  always_comb begin
    f3    = in.op[2:0];
    st    = in.op[3];
    legal = 1'b0;
    misal = 1'b0;
    case (f3)
      3'b000:         legal = 1'b1;
      3'b001: begin   legal = 1'b1; misal = in.addr[0];    end
      3'b010: begin   legal = 1'b1; misal = |in.addr[1:0]; end
      3'b100, 3'b101: begin
        legal = !st;  // unsigned variants exist only for loads
        misal = f3[0] & in.addr[0];
      end
      default:        legal = 1'b0;
    endcase
    fault = !legal || misal;

    case (f3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << in.addr[1:0];
        wdata_n = {4{in.data[7:0]}};
      end
      2'b01: begin
        be_n    = in.addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{in.data[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = in.data;
      end
    endcase
    if (!st) be_n = 4'b1111;
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend.
  logic [31:0] sh, ld_data;

  always_comb begin
    sh = dmem_rdata >> {dmem_addr[1:0], 3'b000};
    case (ld_f3)
      3'b000:  ld_data = {{24{sh[7]}},  sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_data = {24'd0,        sh[7:0]};
      3'b101:  ld_data = {16'd0,        sh[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rd       <= '0;
      out_rd_valid <= 1'b0;
      out_data     <= '0;
      out_fault    <= 1'b0;
      ld_f3        <= '0;
      pc_q         <= '0;
      rd_q         <= '0;
      rdv_q        <= 1'b0;
    end else begin
      // A consumed result drops unless a new one is loaded below.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: if (accept) begin
          if (!in.is_mem || fault) begin
            out_valid    <= 1'b1;
            out_pc       <= in.pc;
            out_rd       <= in.rd;
            out_rd_valid <= in.is_mem ? 1'b0 : in.rd_valid;
            out_data     <= in.is_mem ? '0 : in.data;
            out_fault    <= in.is_mem;
          end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= st;
            dmem_addr  <= in.addr;
            dmem_be    <= be_n;
            dmem_wdata <= wdata_n;
            ld_f3      <= f3;
            pc_q       <= in.pc;
            rd_q       <= in.rd;
            rdv_q      <= in.rd_valid;
            state      <= WAIT;
          end
        end
        WAIT: if (dmem_ack) begin
          // out_valid is already clear here: accept required a free slot.
          dmem_req     <= 1'b0;
          state        <= IDLE;
          out_valid    <= 1'b1;
          out_pc       <= pc_q;
          out_rd       <= rd_q;
          out_fault    <= 1'b0;
          out_data     <= dmem_we ? '0 : ld_data;
          out_rd_valid <= dmem_we ? 1'b0 : rdv_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;
  logic             clk = 1'b0;
  logic             rst;
  rvcpu::stage_ex_t in_s;
  logic             in_valid, in_ready;
  logic             dmem_req, dmem_we, dmem_ack;
  logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]       dmem_be;
  logic             out_valid, out_ready, out_rd_valid, out_fault;
  rvcpu::pc_t       out_pc;
  rvcpu::reg_t      out_rd;
  logic [31:0]      out_data;

  int checks   = 0;
  int failures = 0;

  stage_mem dut (
    .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid), .in_ready(in_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rd_valid(out_rd_valid), .out_data(out_data), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        is_mem;
    logic [3:0]  op;
    logic [31:0] addr, data, rdata;
    logic [4:0]  rd;
    logic        rdv;
    logic        e_fault, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_data;
    logic        e_rdv;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " dmem_req"},   dmem_req, 0);
    chk({nm, " dmem_we"},    dmem_we, 0);
    chk({nm, " dmem_addr"},  dmem_addr, 0);
    chk({nm, " dmem_be"},    dmem_be, 0);
    chk({nm, " dmem_wdata"}, dmem_wdata, 0);
    chk({nm, " out_valid"},  out_valid, 0);
    chk({nm, " out_pc"},     out_pc, 0);
    chk({nm, " out_rd"},     out_rd, 0);
    chk({nm, " out_rdv"},    out_rd_valid, 0);
    chk({nm, " out_data"},   out_data, 0);
    chk({nm, " out_fault"},  out_fault, 0);
    chk({nm, " in_ready"},   in_ready, 1);
  endtask

  // Reference model: derives the expected response from access size and
  // offset arithmetic rather than from any lane decode tables.
  function automatic vec_t model(logic is_mem, logic [3:0] op, logic [31:0] addr,
                                 logic [31:0] data, logic [31:0] rdata,
                                 logic [4:0] rd, logic rdv);
    vec_t   v;
    int     bytes, off;
    longint val;
    logic   bad;
    v = '{"rand", is_mem, op, addr, data, rdata, rd, rdv,
          1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
    if (!is_mem) begin
      v.e_data = data;
      v.e_rdv  = rdv;
      return v;
    end
    off   = int'(addr[1:0]);
    bytes = 1 << op[1:0];
    bad   = (op[1:0] == 2'b11) || (op[2] && (op[3] || op[1])) || ((off % bytes) != 0);
    if (bad) begin
      v.e_fault = 1'b1;
      return v;
    end
    v.e_req = 1'b1;
    v.e_we  = op[3];
    if (op[3]) begin
      v.e_be    = 4'(((1 << bytes) - 1) << off);
      v.e_wdata = (bytes == 1) ? data[7:0] * 32'h0101_0101 :
                  (bytes == 2) ? data[15:0] * 32'h0001_0001 : data;
    end else begin
      v.e_be = 4'hF;
      val = longint'(rdata) >> (8 * off);
      if (bytes < 4) begin
        val = val % (64'sd1 << (8 * bytes));
        if (!op[2] && val >= (64'sd1 << (8 * bytes - 1))) val = val - (64'sd1 << (8 * bytes));
      end
      v.e_data = 32'(val);
      v.e_rdv  = rdv;
    end
    return v;
  endfunction

  // Presents one op, services the memory port with nreq request cycles,
  // checks the result, and holds it unconsumed for 'hold' cycles.
  task automatic run_txn(vec_t v, int nreq, int hold);
    logic [31:0] pc;
    int          n;
    pc        = $urandom;
    in_s      = '{pc: pc, rd: v.rd, rd_valid: v.rdv, is_mem: v.is_mem, op: v.op,
                  addr: v.addr, data: v.data};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({v.name, " accept"}, in_ready, 1);
    if (!in_ready) begin in_valid = 1'b0; return; end
    tick();
    in_valid    = 1'b0;
    in_s.data   = $urandom;
    in_s.addr   = $urandom;
    if (v.e_req) begin
      chk({v.name, " out_valid_wait"}, out_valid, 0);
      chk({v.name, " in_ready_wait"}, in_ready, 0);
      for (int i = 0; i < nreq; i++) begin
        chk({v.name, " req"},  dmem_req, 1);
        chk({v.name, " we"},   dmem_we, v.e_we);
        chk({v.name, " addr"}, dmem_addr, v.addr);
        chk({v.name, " be"},   dmem_be, v.e_be);
        if (v.e_we) chk({v.name, " wdata"}, dmem_wdata, v.e_wdata);
        dmem_ack   = (i == nreq - 1);
        dmem_rdata = (i == nreq - 1) ? v.rdata : $urandom;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
      chk({v.name, " req_drop"}, dmem_req, 0);
    end else begin
      chk({v.name, " no_req"}, dmem_req, 0);
    end
    chk({v.name, " out_valid"}, out_valid, 1);
    chk({v.name, " out_fault"}, out_fault, v.e_fault);
    chk({v.name, " out_data"},  out_data, v.e_data);
    chk({v.name, " out_rdv"},   out_rd_valid, v.e_rdv);
    chk({v.name, " out_rd"},    out_rd, v.rd);
    chk({v.name, " out_pc"},    out_pc, pc);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({v.name, " hold_valid"}, out_valid, 1);
      chk({v.name, " hold_data"},  out_data, v.e_data);
      chk({v.name, " hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({v.name, " consumed"}, out_valid, 0);
  endtask

  vec_t tbl[17];

  initial begin
    vec_t        v;
    logic [3:0]  legal_ops[8];
    logic [3:0]  op;
    logic        is_mem;

    tbl[0]  = '{"alu",      0, 4'h0, 32'h0,   32'h1234_5678, 32'h0,         5'd5,  1, 0, 0, 0, 4'h0, 32'h0,         32'h1234_5678, 1};
    tbl[1]  = '{"lb",       1, 4'h0, 32'h103, 32'h0,         32'h80FF_0000, 5'd6,  1, 0, 1, 0, 4'hF, 32'h0,         32'hFFFF_FF80, 1};
    tbl[2]  = '{"lbu",      1, 4'h4, 32'h103, 32'h0,         32'h80FF_0000, 5'd6,  1, 0, 1, 0, 4'hF, 32'h0,         32'h0000_0080, 1};
    tbl[3]  = '{"sh_hi",    1, 4'h9, 32'h202, 32'hAAAA_BEEF, 32'h0,         5'd7,  1, 0, 1, 1, 4'hC, 32'hBEEF_BEEF, 32'h0,         0};
    tbl[4]  = '{"lw_mis",   1, 4'h2, 32'h101, 32'h0,         32'h0,         5'd8,  1, 1, 0, 0, 4'h0, 32'h0,         32'h0,         0};
    tbl[5]  = '{"ld_f3_3",  1, 4'h3, 32'h100, 32'h0,         32'h0,         5'd8,  1, 1, 0, 0, 4'h0, 32'h0,         32'h0,         0};
    tbl[6]  = '{"st_f3_4",  1, 4'hC, 32'h100, 32'h0,         32'h0,         5'd8,  1, 1, 0, 0, 4'h0, 32'h0,         32'h0,         0};
    tbl[7]  = '{"st_f3_7",  1, 4'hF, 32'h100, 32'h0,         32'h0,         5'd8,  1, 1, 0, 0, 4'h0, 32'h0,         32'h0,         0};
    tbl[8]  = '{"lh",       1, 4'h1, 32'h102, 32'h0,         32'h8001_1234, 5'd9,  1, 0, 1, 0, 4'hF, 32'h0,         32'hFFFF_8001, 1};
    tbl[9]  = '{"lhu",      1, 4'h5, 32'h102, 32'h0,         32'h8001_1234, 5'd9,  1, 0, 1, 0, 4'hF, 32'h0,         32'h0000_8001, 1};
    tbl[10] = '{"sb",       1, 4'h8, 32'h101, 32'h0000_00A5, 32'h0,         5'd10, 1, 0, 1, 1, 4'h2, 32'hA5A5_A5A5, 32'h0,         0};
    tbl[11] = '{"sw",       1, 4'hA, 32'h104, 32'hDEAD_BEEF, 32'h0,         5'd11, 1, 0, 1, 1, 4'hF, 32'hDEAD_BEEF, 32'h0,         0};
    tbl[12] = '{"lw",       1, 4'h2, 32'h108, 32'h0,         32'hCAFE_F00D, 5'd12, 1, 0, 1, 0, 4'hF, 32'h0,         32'hCAFE_F00D, 1};
    tbl[13] = '{"sh_mis",   1, 4'h9, 32'h201, 32'h0,         32'h0,         5'd13, 1, 1, 0, 0, 4'h0, 32'h0,         32'h0,         0};
    tbl[14] = '{"lh_lo",    1, 4'h1, 32'h100, 32'h0,         32'h1234_7FFE, 5'd14, 1, 0, 1, 0, 4'hF, 32'h0,         32'h0000_7FFE, 1};
    tbl[15] = '{"lw_rdv0",  1, 4'h2, 32'h10C, 32'h0,         32'h0000_0001, 5'd15, 0, 0, 1, 0, 4'hF, 32'h0,         32'h0000_0001, 0};
    tbl[16] = '{"ld_f3_7",  1, 4'h7, 32'h100, 32'h0,         32'h0,         5'd16, 1, 1, 0, 0, 4'h0, 32'h0,         32'h0,         0};

    rst        = 1'b1;
    in_s       = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    // ALU pass-through, one result per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_s = '{pc: 32'h40 + 32'(4 * i), rd: 5'd5, rd_valid: 1'b1, is_mem: 1'b0, op: 4'h0,
               addr: 32'h0, data: 32'h1234_5678 + 32'(i)};
      #1;
      chk("alu_stream in_ready", in_ready, 1);
      tick();
      chk("alu_stream valid", out_valid, 1);
      chk("alu_stream data", out_data, 32'h1234_5678 + 32'(i));
      chk("alu_stream rd", out_rd, 5);
    end
    in_valid = 1'b0;
    tick();
    chk("alu_stream drain", out_valid, 0);

    // Back-pressure: held result blocks a pending load
    in_s = '{pc: 32'h80, rd: 5'd3, rd_valid: 1'b1, is_mem: 1'b0, op: 4'h0,
             addr: 32'h0, data: 32'h55};
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    tick();
    in_s = '{pc: 32'h84, rd: 5'd4, rd_valid: 1'b1, is_mem: 1'b1, op: 4'h2,
             addr: 32'h300, data: 32'h0};
    for (int i = 0; i < 3; i++) begin
      chk("bp in_ready", in_ready, 0);
      chk("bp no_req", dmem_req, 0);
      chk("bp held_valid", out_valid, 1);
      chk("bp held_data", out_data, 32'h55);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp req", dmem_req, 1);
    chk("bp drained", out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      chk("bp stable_addr", dmem_addr, 32'h300);
      chk("bp stable_be", dmem_be, 4'hF);
      chk("bp stable_we", dmem_we, 0);
      chk("bp stable_req", dmem_req, 1);
      tick();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1122_3344;
    tick();
    dmem_ack = 1'b0;
    chk("bp load_data", out_data, 32'h1122_3344);
    chk("bp load_valid", out_valid, 1);
    chk("bp req_drop", dmem_req, 0);
    tick();
    chk("bp consumed", out_valid, 0);

    // Reset during an outstanding request, then a stray ack
    in_s = '{pc: 32'h90, rd: 5'd2, rd_valid: 1'b1, is_mem: 1'b1, op: 4'h2,
             addr: 32'h400, data: 32'h0};
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    chk("rst_wait req", dmem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_wait");
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    chk("stray_ack valid", out_valid, 0);
    chk("stray_ack req", dmem_req, 0);
    chk("stray_ack data", out_data, 0);
    chk("stray_ack in_ready", in_ready, 1);

    // Directed vector table
    for (int i = 0; i < 17; i++)
      run_txn(tbl[i], (i == 1) ? 3 : 1 + (i % 3), i % 2);

    // Randomized ops against the reference model
    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
    for (int i = 0; i < 200; i++) begin
      is_mem = ($urandom_range(0, 4) != 0);
      op     = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 7)]
                                           : 4'($urandom_range(0, 15));
      v = model(is_mem, op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
      run_txn(v, $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
